// File: rtl/cpu_harness_pkg.sv
// cpu_harness_pkg
// Shared types for the CPU run harness: the run-controller state encoding
// and the default register_v0 width. No ports.
package cpu_harness_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RESET  = 3'd1,
    ENABLE = 3'd2,
    RUN    = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int DATA_W_DEFAULT = 32;

endpackage

// File: rtl/cpu_harness_channel.sv
// cpu_harness_channel
// Per-CPU monitor: tracks whether the channel has finished, captures
// register_v0 when active falls during the run, and holds the sticky
// rw_conflict / start_fault flags.
// Ports:
//   clk, rst        clock, async active-high reset
//   clear           run start: wipe all per-run state
//   check_start     ENABLE cycle: active must be high here
//   run             RUN cycle: monitor active / read / write
//   active, data_read, data_write, register_v0   CPU signals
//   finished        channel already done (registered)
//   finishing       channel finishes on this edge (combinational)
//   result, result_valid, rw_conflict, start_fault   per-channel outputs
module cpu_harness_channel
  import cpu_harness_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              check_start,
  input  logic              run,
  input  logic              active,
  input  logic              data_read,
  input  logic              data_write,
  input  logic [DATA_W-1:0] register_v0,
  output logic              finished,
  output logic              finishing,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              rw_conflict,
  output logic              start_fault
);

  assign finishing = run & ~finished & ~active;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      finished     <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      rw_conflict  <= 1'b0;
      start_fault  <= 1'b0;
    end else if (clear) begin
      finished     <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      rw_conflict  <= 1'b0;
      start_fault  <= 1'b0;
    end else if (check_start) begin
      // A CPU that is not active right after reset is counted as finished
      // without a result so it cannot hold the run open.
      if (!active) begin
        start_fault <= 1'b1;
        finished    <= 1'b1;
      end
    end else if (run && !finished) begin
      // Gating on !finished keeps a stale or X register_v0 out of result.
      if (!active) begin
        finished     <= 1'b1;
        result       <= register_v0;
        result_valid <= 1'b1;
      end else if (data_read && data_write) begin
        rw_conflict <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_run_harness.sv
// cpu_run_harness
// Run controller for NUM_CPUS CPUs sharing one clock: sequences cpu_reset
// and cpu_clk_enable, counts RUN cycles, watchdogs the run and collects
// per-channel results and fault flags.
// Ports:
//   clk, reset                        clock, async active-high reset
//   start                             begin a run (IDLE/DONE only)
//   cpu_reset, cpu_clk_enable         drive to all CPUs
//   cpu_active/data_read/data_write   per-CPU status, one bit per channel
//   cpu_register_v0                   channel i at [i*DATA_W +: DATA_W]
//   cycle_count                       RUN cycles elapsed, saturating
//   result, result_valid              captured v0 per channel
//   rw_conflict, start_fault          sticky per-channel flags
//   timeout, done, pass               run outcome
module cpu_run_harness
  import cpu_harness_pkg::*;
#(
  parameter int NUM_CPUS       = 1,
  parameter int DATA_W         = DATA_W_DEFAULT,
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 20,
  parameter int RESET_CYCLES   = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic                       cpu_reset,
  output logic                       cpu_clk_enable,
  input  logic [NUM_CPUS-1:0]        cpu_active,
  input  logic [NUM_CPUS-1:0]        cpu_data_read,
  input  logic [NUM_CPUS-1:0]        cpu_data_write,
  input  logic [NUM_CPUS*DATA_W-1:0] cpu_register_v0,
  output logic [CNT_W-1:0]           cycle_count,
  output logic [NUM_CPUS*DATA_W-1:0] result,
  output logic [NUM_CPUS-1:0]        result_valid,
  output logic [NUM_CPUS-1:0]        rw_conflict,
  output logic [NUM_CPUS-1:0]        start_fault,
  output logic                       timeout,
  output logic                       done,
  output logic                       pass
);

  localparam int RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  state_t              state;
  logic [RST_W-1:0]    rst_cnt;
  logic [CNT_W-1:0]    cnt_inc;
  logic                start_accept;
  logic [NUM_CPUS-1:0] chan_finished;
  logic [NUM_CPUS-1:0] chan_finishing;

  assign start_accept = start && (state == IDLE || state == DONE);
  assign cnt_inc      = (&cycle_count) ? cycle_count : cycle_count + CNT_W'(1);

  // Decoded from registered flags only, so it settles with done.
  assign pass = done & ~timeout & ~|rw_conflict & ~|start_fault;

  for (genvar i = 0; i < NUM_CPUS; i++) begin : g_chan
    cpu_harness_channel #(.DATA_W(DATA_W)) u_chan (
      .clk          (clk),
      .rst          (reset),
      .clear        (start_accept),
      .check_start  (state == ENABLE),
      .run          (state == RUN),
      .active       (cpu_active[i]),
      .data_read    (cpu_data_read[i]),
      .data_write   (cpu_data_write[i]),
      .register_v0  (cpu_register_v0[i*DATA_W +: DATA_W]),
      .finished     (chan_finished[i]),
      .finishing    (chan_finishing[i]),
      .result       (result[i*DATA_W +: DATA_W]),
      .result_valid (result_valid[i]),
      .rw_conflict  (rw_conflict[i]),
      .start_fault  (start_fault[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cpu_reset      <= 1'b1;
      cpu_clk_enable <= 1'b0;
      rst_cnt        <= '0;
      cycle_count    <= '0;
      timeout        <= 1'b0;
      done           <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state          <= RESET;
            cpu_reset      <= 1'b1;
            cpu_clk_enable <= 1'b0;
            rst_cnt        <= RST_W'(RESET_CYCLES - 1);
            cycle_count    <= '0;
            timeout        <= 1'b0;
            done           <= 1'b0;
          end
        end
        RESET: begin
          if (rst_cnt == '0) begin
            state          <= ENABLE;
            cpu_reset      <= 1'b0;
            cpu_clk_enable <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt - 1'b1;
          end
        end
        ENABLE: begin
          if (~|cpu_active) begin
            state          <= DONE;
            cpu_clk_enable <= 1'b0;
            done           <= 1'b1;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          cycle_count <= cnt_inc;
          // Finishing on the timeout cycle takes priority over the watchdog.
          if (&(chan_finished | chan_finishing)) begin
            state          <= DONE;
            cpu_clk_enable <= 1'b0;
            done           <= 1'b1;
          end else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
            state          <= DONE;
            cpu_clk_enable <= 1'b0;
            timeout        <= 1'b1;
            done           <= 1'b1;
          end
        end
        default: begin
          state          <= IDLE;
          cpu_reset      <= 1'b1;
          cpu_clk_enable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_harness.sv
module tb_cpu_run_harness;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // single-channel instance
  logic        start1 = 1'b0;
  logic [0:0]  act1 = 1'b1, rd1 = 1'b0, wr1 = 1'b0;
  logic [31:0] v01 = 32'h2A;
  logic        cpu_reset1, en1, to1, done1, pass1;
  logic [31:0] cnt1, res1;
  logic [0:0]  rv1, rwc1, sf1;

  cpu_run_harness #(.NUM_CPUS(1), .DATA_W(32), .CNT_W(32),
                    .TIMEOUT_CYCLES(20), .RESET_CYCLES(2)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1),
    .cpu_reset(cpu_reset1), .cpu_clk_enable(en1),
    .cpu_active(act1), .cpu_data_read(rd1), .cpu_data_write(wr1),
    .cpu_register_v0(v01), .cycle_count(cnt1), .result(res1),
    .result_valid(rv1), .rw_conflict(rwc1), .start_fault(sf1),
    .timeout(to1), .done(done1), .pass(pass1));

  // three-channel instance
  logic        start3 = 1'b0;
  logic [2:0]  act3 = 3'b111, rd3 = 3'b000, wr3 = 3'b000;
  logic [95:0] v03 = {32'd3, 32'd2, 32'd1};
  logic        cpu_reset3, en3, to3, done3, pass3;
  logic [31:0] cnt3;
  logic [95:0] res3;
  logic [2:0]  rv3, rwc3, sf3;

  cpu_run_harness #(.NUM_CPUS(3), .DATA_W(32), .CNT_W(32),
                    .TIMEOUT_CYCLES(20), .RESET_CYCLES(2)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3),
    .cpu_reset(cpu_reset3), .cpu_clk_enable(en3),
    .cpu_active(act3), .cpu_data_read(rd3), .cpu_data_write(wr3),
    .cpu_register_v0(v03), .cycle_count(cnt3), .result(res3),
    .result_valid(rv3), .rw_conflict(rwc3), .start_fault(sf3),
    .timeout(to3), .done(done3), .pass(pass3));

  // snapshots taken during start-up sequencing
  logic s1_rst, s1_en, s1_done, s2_rst, s2_en, s3_rst, s3_en;
  logic [2:0]  s1_flags;
  logic [95:0] s1_res;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Channel finishes on RUN cycle f (active low at that edge); f=0 never-active
  // is not used here, large f means active held high.
  task automatic run1(input int f);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    s1_rst = cpu_reset1; s1_en = en1; s1_done = done1;
    @(negedge clk);
    s2_rst = cpu_reset1; s2_en = en1;
    @(negedge clk);
    s3_rst = cpu_reset1; s3_en = en1;
    act1 = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done1) break;
      act1 = (k != f);
      v01  = (k <= f) ? 32'h2A : 32'hDEADBEEF;
    end
    act1 = 1'b1;
    v01  = 32'h2A;
  endtask

  // f=0: channel inactive at ENABLE. r: cycle of a 1-cycle read&write pulse (0=none).
  // After its finish cycle a channel raises active again and presents junk v0.
  task automatic run3(input int f0, input int f1, input int f2,
                      input int r0, input int r1, input int r2);
    int fa[3];
    int ra[3];
    fa[0] = f0; fa[1] = f1; fa[2] = f2;
    ra[0] = r0; ra[1] = r1; ra[2] = r2;
    act3 = 3'b111;
    v03  = {32'd3, 32'd2, 32'd1};
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    s1_done = done3; s1_flags = rwc3 | rv3 | sf3; s1_res = res3;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) act3[i] = (fa[i] != 0);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done3) break;
      for (int i = 0; i < 3; i++) begin
        act3[i] = (k != fa[i]);
        v03[i*32 +: 32] = (k <= fa[i]) ? 32'(i + 1) : 32'hDEAD0000;
        rd3[i] = (k == ra[i]);
        wr3[i] = (k == ra[i]);
      end
    end
    act3 = 3'b111;
    rd3  = 3'b000;
    wr3  = 3'b000;
    v03  = {32'd3, 32'd2, 32'd1};
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_cpu_reset", cpu_reset1, 1'b1);
    chk("rst_clk_en", en1, 1'b0);
    chk("rst_outs1", {cnt1, res1, rv1, rwc1, sf1, to1, done1, pass1}, '0);
    chk("rst_outs3", {cnt3, res3, rv3, rwc3, sf3, to3, done3, pass3}, '0);
    reset = 1'b0;
    @(negedge clk);

    // A: single channel finishes on RUN cycle 7
    run1(7);
    chk("A_reset_c1", {s1_rst, s1_en}, 2'b10);
    chk("A_reset_c2", {s2_rst, s2_en}, 2'b10);
    chk("A_enable",   {s3_rst, s3_en}, 2'b01);
    chk("A_result", res1, 32'h2A);
    chk("A_valid", rv1, 1'b1);
    chk("A_count", cnt1, 32'd7);
    chk("A_done_pass_to", {done1, pass1, to1}, 3'b110);
    chk("A_done_outs", {cpu_reset1, en1}, 2'b00);

    // B: active held high -> watchdog at 20
    run1(1000);
    chk("B_clear_done", s1_done, 1'b0);
    chk("B_done_pass_to", {done1, pass1, to1}, 3'b101);
    chk("B_valid", rv1, 1'b0);
    chk("B_result", res1, 32'h0);
    chk("B_count", cnt1, 32'd20);

    // C: finish on cycle 20 beats the watchdog
    run1(20);
    chk("C_done_pass_to", {done1, pass1, to1}, 3'b110);
    chk("C_count", cnt1, 32'd20);
    chk("C_valid_res", {rv1, res1}, {1'b1, 32'h2A});

    // D: three channels finish 3/9/5, rw pulse on ch1@4 and on finished ch0@6
    run3(3, 9, 5, 6, 4, 0);
    chk("D_count", cnt3, 32'd9);
    chk("D_result", res3, {32'd3, 32'd2, 32'd1});
    chk("D_valid", rv3, 3'b111);
    chk("D_rw", rwc3, 3'b010);
    chk("D_sf", sf3, 3'b000);
    chk("D_done_pass_to", {done3, pass3, to3}, 3'b100);

    // E: restart from DONE, ch1 inactive at ENABLE
    run3(3, 0, 5, 0, 0, 0);
    chk("E_clear_done", s1_done, 1'b0);
    chk("E_clear_flags", s1_flags, 3'b000);
    chk("E_clear_res", s1_res, 96'h0);
    chk("E_sf", sf3, 3'b010);
    chk("E_valid", rv3, 3'b101);
    chk("E_result", res3, {32'd3, 32'd0, 32'd1});
    chk("E_rw", rwc3, 3'b000);
    chk("E_count", cnt3, 32'd5);
    chk("E_done_pass_to", {done3, pass3, to3}, 3'b100);

    // G: start ignored in RUN, then reset mid-run
    act3 = 3'b111;
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    repeat (4) @(negedge clk);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    chk("G_start_ignored", {cpu_reset3, en3}, 2'b01);
    @(negedge clk);
    chk("G_count_running", cnt3, 32'd3);
    reset = 1'b1;
    #1;
    chk("G_abort_ctl", {cpu_reset3, en3}, 2'b10);
    chk("G_abort_outs", {cnt3, res3, rv3, rwc3, sf3, to3, done3, pass3}, '0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // F: clean run after the abort
    run3(2, 2, 2, 0, 0, 0);
    chk("F_count", cnt3, 32'd2);
    chk("F_result", res3, {32'd3, 32'd2, 32'd1});
    chk("F_flags", {rv3, rwc3, sf3}, 9'b111_000_000);
    chk("F_done_pass_to", {done3, pass3, to3}, 3'b110);

    // H: every channel inactive at ENABLE -> straight to DONE
    run3(0, 0, 0, 0, 0, 0);
    chk("H_count", cnt3, 32'd0);
    chk("H_flags", {rv3, sf3}, 6'b000_111);
    chk("H_done_pass_to", {done3, pass3, to3}, 3'b100);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
